// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencing and the min:sec counters behind the stopwatch display.
// Latency: raw inputs reach decisions after SYNC_STAGES edges; tick enables update counters on the edge they are sampled.
// Backpressure: none; tick enables and button/switch levels are consumed every cycle and never stalled.

module stopwatch_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_ref,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

module stopwatch_ctrl #(
    parameter int MIN_MAX     = 99,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_ref,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_blink,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [6:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       adjusting,
    output logic       blank_min,
    output logic       blank_sec
);
    localparam logic [6:0] MIN_TOP = 7'(MIN_MAX);
    localparam logic [5:0] SEC_TOP = 6'd59;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       pause_s, reset_s, adj_s, sel_s;
    logic       pause_d;
    logic       pause_evt;
    logic       blink_phase;
    logic [6:0] min_nxt;
    logic [5:0] sec_nxt;

    stopwatch_sync #(.STAGES(SYNC_STAGES)) u_sync_pause (
        .clk_ref(clk_ref), .rst_n(rst_n), .d(btn_pause), .q(pause_s));
    stopwatch_sync #(.STAGES(SYNC_STAGES)) u_sync_reset (
        .clk_ref(clk_ref), .rst_n(rst_n), .d(btn_reset), .q(reset_s));
    stopwatch_sync #(.STAGES(SYNC_STAGES)) u_sync_adj (
        .clk_ref(clk_ref), .rst_n(rst_n), .d(sw_adj), .q(adj_s));
    stopwatch_sync #(.STAGES(SYNC_STAGES)) u_sync_sel (
        .clk_ref(clk_ref), .rst_n(rst_n), .d(sw_sel), .q(sel_s));

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            pause_d <= 1'b0;
        end else begin
            pause_d <= pause_s;
        end
    end

    // One pulse per press, however long the button is held.
    assign pause_evt = pause_s & ~pause_d;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (adj_s) begin
                    state_nxt = ST_ADJUST;
                end else if (pause_evt) begin
                    state_nxt = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (adj_s) begin
                    state_nxt = ST_ADJUST;
                end else if (pause_evt) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (!adj_s) begin
                    state_nxt = ST_PAUSED;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        running   = 1'b0;
        adjusting = 1'b0;
        unique case (state)
            ST_RUN:    running   = 1'b1;
            ST_ADJUST: adjusting = 1'b1;
            default: ;
        endcase
    end

    // Counters act on the registered (pre-transition) state, so a tick that
    // lands with a mode change still follows the old mode's rule.
    always_comb begin
        min_nxt = min;
        sec_nxt = sec;
        if (reset_s) begin
            min_nxt = '0;
            sec_nxt = '0;
        end else if (state == ST_RUN && tick_1hz) begin
            if (sec == SEC_TOP) begin
                sec_nxt = '0;
                min_nxt = (min == MIN_TOP) ? 7'd0 : min + 7'd1;
            end else begin
                sec_nxt = sec + 6'd1;
            end
        end else if (state == ST_ADJUST && tick_2hz) begin
            if (sel_s) begin
                sec_nxt = (sec == SEC_TOP) ? 6'd0 : sec + 6'd1;
            end else begin
                min_nxt = (min == MIN_TOP) ? 7'd0 : min + 7'd1;
            end
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            min <= '0;
            sec <= '0;
        end else begin
            min <= min_nxt;
            sec <= sec_nxt;
        end
    end

    // Blink phase only advances while staying in ADJUST; any entry or exit
    // leaves it at 0 so the selected field always starts visible.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            blink_phase <= 1'b0;
        end else if (state == ST_ADJUST && state_nxt == ST_ADJUST) begin
            blink_phase <= blink_phase ^ tick_blink;
        end else begin
            blink_phase <= 1'b0;
        end
    end

    assign blank_sec = adjusting &  sel_s & blink_phase;
    assign blank_min = adjusting & ~sel_s & blink_phase;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus a randomized run, all
// compared against a mode/time-of-day model that tracks elapsed seconds.
module tb_stopwatch_ctrl;
    localparam int MIN_MAX = 99;
    localparam int SYNC    = 2;
    localparam int M_RUN = 0, M_PAUSED = 1, M_ADJ = 2;

    logic       clk_ref = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_blink = 1'b0;
    logic       btn_pause = 1'b0, btn_reset = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
    logic [6:0] min;
    logic [5:0] sec;
    logic       running, adjusting, blank_min, blank_sec;

    int n_chk  = 0;
    int n_pass = 0;

    int m_min, m_sec, m_mode;
    bit m_blink, m_pd;
    bit h_pause[SYNC], h_reset[SYNC], h_adj[SYNC], h_sel[SYNC];

    stopwatch_ctrl #(.MIN_MAX(MIN_MAX), .SYNC_STAGES(SYNC)) dut (
        .clk_ref(clk_ref), .rst_n(rst_n),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_blink(tick_blink),
        .btn_pause(btn_pause), .btn_reset(btn_reset), .sw_adj(sw_adj), .sw_sel(sw_sel),
        .min(min), .sec(sec), .running(running), .adjusting(adjusting),
        .blank_min(blank_min), .blank_sec(blank_sec));

    always #5 clk_ref = ~clk_ref;

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_mode = M_RUN; m_blink = 0; m_pd = 0;
        for (int i = 0; i < SYNC; i++) begin
            h_pause[i] = 0; h_reset[i] = 0; h_adj[i] = 0; h_sel[i] = 0;
        end
    endtask

    // h_*[i] holds the raw value sampled i+1 edges ago; the oldest entry is
    // what the synchronized signal shows to decisions at this edge.
    task automatic model_edge();
        bit p, r, a, sl, evt;
        int t, nmode;
        p = h_pause[SYNC-1]; r = h_reset[SYNC-1]; a = h_adj[SYNC-1]; sl = h_sel[SYNC-1];
        evt = p && !m_pd;
        m_pd = p;
        if (r) begin
            m_min = 0; m_sec = 0;
        end else if (m_mode == M_RUN && tick_1hz) begin
            t = (m_min * 60 + m_sec + 1) % ((MIN_MAX + 1) * 60);
            m_min = t / 60; m_sec = t % 60;
        end else if (m_mode == M_ADJ && tick_2hz) begin
            if (sl) m_sec = (m_sec + 1) % 60;
            else    m_min = (m_min + 1) % (MIN_MAX + 1);
        end
        nmode = m_mode;
        if (m_mode != M_ADJ && a)             nmode = M_ADJ;
        else if (m_mode == M_RUN && evt)      nmode = M_PAUSED;
        else if (m_mode == M_PAUSED && evt)   nmode = M_RUN;
        else if (m_mode == M_ADJ && !a)       nmode = M_PAUSED;
        if (m_mode == M_ADJ && nmode == M_ADJ) m_blink = m_blink ^ tick_blink;
        else                                   m_blink = 0;
        m_mode = nmode;
        for (int i = SYNC - 1; i > 0; i--) begin
            h_pause[i] = h_pause[i-1]; h_reset[i] = h_reset[i-1];
            h_adj[i] = h_adj[i-1];     h_sel[i] = h_sel[i-1];
        end
        h_pause[0] = btn_pause; h_reset[0] = btn_reset; h_adj[0] = sw_adj; h_sel[0] = sw_sel;
    endtask

    function automatic logic [16:0] exp_vec();
        bit adj, sl;
        adj = (m_mode == M_ADJ);
        sl  = h_sel[SYNC-1];
        return {7'(m_min), 6'(m_sec), m_mode == M_RUN, adj,
                adj & ~sl & m_blink, adj & sl & m_blink};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {min, sec, running, adjusting, blank_min, blank_sec};
    endfunction

    // Drive ticks for one cycle; outputs are sampled on the following negedge.
    task automatic cycle(input bit t1, input bit t2, input bit tb);
        tick_1hz = t1; tick_2hz = t2; tick_blink = tb;
        @(posedge clk_ref);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk_ref);
        tick_1hz = 0; tick_2hz = 0; tick_blink = 0;
    endtask

    task automatic adj_to(input int mm, input int ss);
        int guard;
        sw_adj = 1; sw_sel = 0;
        repeat (SYNC + 1) cycle(0, 0, 0);
        guard = 0;
        while (m_min != mm && guard < 300) begin cycle(0, 1, 0); guard++; end
        sw_sel = 1;
        repeat (SYNC + 1) cycle(0, 0, 0);
        while (m_sec != ss && guard < 600) begin cycle(0, 1, 0); guard++; end
        if (guard >= 300 && (m_min != mm || m_sec != ss)) begin
            n_chk++;
            $display("FAIL adj_to_timeout: model at %0d:%0d, wanted %0d:%0d", m_min, m_sec, mm, ss);
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 0;
        repeat (3) cycle(1, 1, 1);
        n_chk++;
        if (dut_vec() !== {7'd0, 6'd0, 4'b1000})
            $display("FAIL reset_values: got %h want %h", dut_vec(), {7'd0, 6'd0, 4'b1000});
        else n_pass++;
        rst_n = 1;
        cycle(0, 0, 0);
        n_chk++;
        if (dut_vec() !== exp_vec()) $display("FAIL after_release: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 61; i++) begin
            cycle(1, $urandom_range(0, 1), $urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) cycle(0, $urandom_range(0, 1), 0);
        end
        n_chk++;
        if (dut_vec() !== exp_vec()) $display("FAIL free_run_model: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
        n_chk++;
        if (min !== 7'd1 || sec !== 6'd1 || running !== 1'b1)
            $display("FAIL free_run_61: got %0d:%0d run=%b want 1:1 run=1", min, sec, running);
        else n_pass++;
    endtask

    task automatic test_adjust();
        int min0;
        bit prev;
        min0 = m_min;
        adj_to(min0, 58);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        n_chk++;
        if (sec !== 6'd1 || min !== 7'(min0) || adjusting !== 1'b1)
            $display("FAIL adjust_no_carry: got %0d:%0d adj=%b want %0d:1 adj=1", min, sec, adjusting, min0);
        else n_pass++;
        prev = blank_sec;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) cycle(0, 0, 0);
            cycle(0, 0, 1);
            n_chk++;
            if (blank_sec !== ~prev || blank_min !== 1'b0 || dut_vec() !== exp_vec())
                $display("FAIL blink_toggle: got bs=%b bm=%b want bs=%b bm=0", blank_sec, blank_min, ~prev);
            else n_pass++;
            prev = blank_sec;
        end
        sw_adj = 0;
        repeat (SYNC + 1) cycle(0, 0, 1);
        n_chk++;
        if (running !== 1'b0 || adjusting !== 1'b0 || blank_min !== 1'b0 || blank_sec !== 1'b0
            || dut_vec() !== exp_vec())
            $display("FAIL adjust_exit: got %h want paused %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic press_pause(input int hold);
        btn_pause = 1;
        repeat (hold) cycle(0, 0, 0);
        btn_pause = 0;
        repeat (SYNC + 1) cycle(0, 0, 0);
    endtask

    task automatic test_full_wrap();
        adj_to(MIN_MAX, 59);
        n_chk++;
        if (min !== 7'(MIN_MAX) || sec !== 6'd59)
            $display("FAIL wrap_preload: got %0d:%0d want %0d:59", min, sec, MIN_MAX);
        else n_pass++;
        sw_adj = 0;
        repeat (SYNC + 1) cycle(0, 0, 0);
        press_pause(3);
        cycle(1, 0, 0);
        n_chk++;
        if (min !== 7'd0 || sec !== 6'd0 || running !== 1'b1)
            $display("FAIL full_wrap: got %0d:%0d run=%b want 0:0 run=1", min, sec, running);
        else n_pass++;
    endtask

    task automatic test_pause();
        int sec0;
        btn_pause = 1;
        for (int i = 0; i < 50; i++) cycle(0, 0, 0);
        n_chk++;
        if (running !== 1'b0 || adjusting !== 1'b0)
            $display("FAIL pause_hold: got run=%b adj=%b want run=0 adj=0", running, adjusting);
        else n_pass++;
        btn_pause = 0;
        repeat (SYNC + 1) cycle(0, 0, 0);
        sec0 = sec;
        for (int i = 0; i < 5; i++) cycle(1, 1, 0);
        n_chk++;
        if (sec !== 6'(sec0) || dut_vec() !== exp_vec())
            $display("FAIL paused_hold_count: got sec=%0d want %0d", sec, sec0);
        else n_pass++;
        press_pause(4);
        cycle(1, 0, 0);
        n_chk++;
        if (running !== 1'b1 || sec !== 6'(sec0 + 1))
            $display("FAIL resume: got run=%b sec=%0d want run=1 sec=%0d", running, sec, sec0 + 1);
        else n_pass++;
        // Raw press captured at the first edge; pause_evt fires on the third.
        sec0 = sec;
        btn_pause = 1;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        n_chk++;
        if (sec !== 6'(sec0 + 1) || running !== 1'b0)
            $display("FAIL pause_with_tick: got sec=%0d run=%b want sec=%0d run=0", sec, running, sec0 + 1);
        else n_pass++;
        btn_pause = 0;
        repeat (SYNC + 1) cycle(0, 0, 0);
        press_pause(2);
    endtask

    task automatic test_clear();
        adj_to(3, 20);
        sw_adj = 0;
        repeat (SYNC + 1) cycle(0, 0, 0);
        press_pause(2);
        n_chk++;
        if (min !== 7'd3 || sec !== 6'd20 || running !== 1'b1)
            $display("FAIL clear_setup: got %0d:%0d run=%b want 3:20 run=1", min, sec, running);
        else n_pass++;
        btn_reset = 1;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0);
            n_chk++;
            if (dut_vec() !== exp_vec()) $display("FAIL clear_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (min !== 7'd0 || sec !== 6'd0 || running !== 1'b1)
            $display("FAIL clear_held: got %0d:%0d run=%b want 0:0 run=1", min, sec, running);
        else n_pass++;
        btn_reset = 0;
        repeat (SYNC + 1) cycle(0, 0, 0);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)  btn_pause = ~btn_pause;
            if ($urandom_range(0, 59) == 0) sw_adj = ~sw_adj;
            if ($urandom_range(0, 9) == 0)  sw_sel = ~sw_sel;
            btn_reset = ($urandom_range(0, 79) == 0);
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            n_chk++;
            if (dut_vec() !== exp_vec()) begin
                if (errs < 10) $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
                errs++;
            end else n_pass++;
        end
        btn_pause = 0; btn_reset = 0; sw_adj = 0; sw_sel = 0;
        repeat (SYNC + 2) cycle(0, 0, 0);
    endtask

    task automatic test_async_reset();
        sw_adj = 1;
        repeat (SYNC + 2) cycle(0, 1, 1);
        n_chk++;
        if (adjusting !== 1'b1) $display("FAIL async_setup: got adj=%b want 1", adjusting);
        else n_pass++;
        sw_adj = 0;
        @(posedge clk_ref);
        model_edge();
        #2 rst_n = 0;
        #1;
        n_chk++;
        if (dut_vec() !== {7'd0, 6'd0, 4'b1000})
            $display("FAIL async_reset: got %h want %h", dut_vec(), {7'd0, 6'd0, 4'b1000});
        else n_pass++;
        model_reset();
        @(negedge clk_ref);
        cycle(1, 1, 1);
        rst_n = 1;
        repeat (3) cycle(1, 0, 0);
        n_chk++;
        if (running !== 1'b1 || dut_vec() !== exp_vec())
            $display("FAIL async_resume: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    initial begin
        @(negedge clk_ref);
        test_reset();
        test_free_run();
        test_adjust();
        test_full_wrap();
        test_pause();
        test_clear();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
